// File: rtl/usb_bit_stuffer_if.sv
// Bus between the packet serializer, the bit stuffer and the NRZI encoder.
// With BIT_STUFF_STATS_EN defined the bus also carries the per-packet stuff count.
interface usb_bit_stuffer_if;
    logic       in_valid;
    logic       in_bit;
    logic       in_start;
    logic       in_end;
    logic       stall;
    logic       out_valid;
    logic       out_bit;
    logic       out_start;
    logic       out_end;
`ifdef BIT_STUFF_STATS_EN
    logic [7:0] stuff_cnt;
`endif

    // master: serializer side / encoder side as seen by the surroundings
    modport master (
        output in_valid, in_bit, in_start, in_end,
        input  stall, out_valid, out_bit, out_start, out_end
`ifdef BIT_STUFF_STATS_EN
        , input stuff_cnt
`endif
    );

    // slave: the bit stuffer itself
    modport slave (
        input  in_valid, in_bit, in_start, in_end,
        output stall, out_valid, out_bit, out_start, out_end
`ifdef BIT_STUFF_STATS_EN
        , output stuff_cnt
`endif
    );
endinterface

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after RUN_LEN consecutive 1s, stalling upstream one cycle.
// Optional macro BIT_STUFF_STATS_EN adds a saturating per-packet stuffed-bit counter (stuff_cnt).
module usb_bit_stuffer #(
    parameter int unsigned RUN_LEN = 6
) (
    input  logic               clk,
    input  logic               rst,
    usb_bit_stuffer_if.slave   bus
);
    localparam int unsigned    CW      = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0]  RUN_MAX = CW'(RUN_LEN);

    typedef enum logic [1:0] {IDLE, SEND, STUFF, FINISH} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] ones_reg, ones_next;
    logic          end_pend_reg, end_pend_next;
    logic          out_valid_reg, out_valid_next;
    logic          out_bit_reg, out_bit_next;
    logic          out_start_reg, out_start_next;
    logic          out_end_reg, out_end_next;
    logic          take_bit;
    logic [CW-1:0] ones_base;
    logic [CW-1:0] ones_bumped;
`ifdef BIT_STUFF_STATS_EN
    logic [7:0]    stuff_cnt_reg, stuff_cnt_next;
`endif

    always_comb begin
        state_next     = state_reg;
        ones_next      = ones_reg;
        end_pend_next  = end_pend_reg;
        out_valid_next = 1'b0;
        out_bit_next   = 1'b0;
        out_start_next = 1'b0;
        out_end_next   = 1'b0;
        take_bit       = 1'b0;
        ones_base      = '0;
        ones_bumped    = '0;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid && bus.in_start) begin
                    take_bit       = 1'b1;
                    out_start_next = 1'b1;
                end
            end
            SEND: begin
                take_bit = bus.in_valid;
            end
            STUFF: begin
                out_valid_next = 1'b1;
                out_bit_next   = 1'b0;
                ones_next      = '0;
                state_next     = end_pend_reg ? FINISH : SEND;
            end
            FINISH: begin
                out_end_next = 1'b1;
                ones_next    = '0;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A new packet always starts counting from zero; a gap in SEND just holds the count.
        if (take_bit) begin
            ones_base      = (state_reg == IDLE) ? '0 : ones_reg;
            ones_bumped    = bus.in_bit ? (ones_base + CW'(1)) : '0;
            ones_next      = ones_bumped;
            out_valid_next = 1'b1;
            out_bit_next   = bus.in_bit;
            if (ones_bumped == RUN_MAX) begin
                state_next    = STUFF;
                end_pend_next = bus.in_end;
            end else if (bus.in_end) begin
                state_next = FINISH;
            end else begin
                state_next = SEND;
            end
        end
    end

`ifdef BIT_STUFF_STATS_EN
    always_comb begin
        stuff_cnt_next = stuff_cnt_reg;
        if (take_bit && (state_reg == IDLE)) begin
            stuff_cnt_next = 8'd0;
        end else if ((state_reg == STUFF) && (stuff_cnt_reg != 8'hFF)) begin
            stuff_cnt_next = stuff_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stuff_cnt_reg <= 8'd0;
        end else begin
            stuff_cnt_reg <= stuff_cnt_next;
        end
    end

    assign bus.stuff_cnt = stuff_cnt_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ones_reg      <= '0;
            end_pend_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_bit_reg   <= 1'b0;
            out_start_reg <= 1'b0;
            out_end_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ones_reg      <= ones_next;
            end_pend_reg  <= end_pend_next;
            out_valid_reg <= out_valid_next;
            out_bit_reg   <= out_bit_next;
            out_start_reg <= out_start_next;
            out_end_reg   <= out_end_next;
        end
    end

    // Stall comes straight from the state register so upstream sees no input-to-output path.
    assign bus.stall     = (state_reg == STUFF);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_bit   = out_bit_reg;
    assign bus.out_start = out_start_reg;
    assign bus.out_end   = out_end_reg;
endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Self-checking bench for usb_bit_stuffer: bit-stream model scoreboard plus literal per-packet expectations.
module tb_usb_bit_stuffer;
    localparam int RUN_LEN = 6;

    typedef struct {
        logic b;
        logic stuffed;
        logic first;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    usb_bit_stuffer_if bus ();

    usb_bit_stuffer #(.RUN_LEN(RUN_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    pass_cnt  = 0;
    int    total_cnt = 0;
    exp_t  exp_q[$];
    exp_t  e;
    logic  r;
    logic  end_due   = 1'b0;
    logic  stuff_due = 1'b0;
    logic  exp_stall;
    int    cyc       = 0;
    int    start_cyc = 0;
    int    end_off   = -1;
    int    cap_len   = 0;
    int    stall_cnt = 0;
    logic [31:0] cap_val = '0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: the spec's stuffing rule applied to a whole packet as a bit sequence.
    task automatic model_push(input logic [31:0] bits, input int n);
        int   run = 0;
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.b = bits[i]; x.stuffed = 1'b0; x.first = (i == 0); x.last = 1'b0;
            run = bits[i] ? run + 1 : 0;
            if (run != RUN_LEN) x.last = (i == n - 1);
            exp_q.push_back(x);
            if (run == RUN_LEN) begin
                x.b = 1'b0; x.stuffed = 1'b1; x.first = 1'b0; x.last = (i == n - 1);
                exp_q.push_back(x);
                run = 0;
            end
        end
    endtask

    // Compare process: sampled 2 time units after every rising edge.
    always @(posedge clk) begin
        r = rst;
        #2;
        cyc++;
        if (r) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_bit",   bus.out_bit,   0);
            chk("rst_out_start", bus.out_start, 0);
            chk("rst_out_end",   bus.out_end,   0);
            chk("rst_stall",     bus.stall,     0);
`ifdef BIT_STUFF_STATS_EN
            chk("rst_stuff_cnt", bus.stuff_cnt, 0);
`endif
            exp_q.delete();
            end_due   = 1'b0;
            stuff_due = 1'b0;
        end else begin
            chk("out_end", bus.out_end, end_due);
            if (bus.out_end) end_off = cyc - start_cyc;
            end_due = 1'b0;
            if (stuff_due) chk("stuff_emit", bus.out_valid, 1);
            stuff_due = 1'b0;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", bus.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bit",   bus.out_bit,   e.b);
                    chk("out_start", bus.out_start, e.first);
                    if (e.last) end_due = 1'b1;
                    if (bus.out_start) start_cyc = cyc;
                    if (cap_len < 32) cap_val[cap_len] = bus.out_bit;
                    cap_len++;
                end
            end else begin
                chk("out_start_idle", bus.out_start, 0);
            end
            exp_stall = bus.out_valid && (exp_q.size() > 0) && exp_q[0].stuffed;
            stuff_due = exp_stall;
            chk("stall", bus.stall, exp_stall);
            if (bus.stall) stall_cnt++;
        end
    end

    task automatic send_packet(input logic [31:0] bits, input int n, input int gap_at,
                               input int gap_len, input int abort_at);
        int i = 0;
        int guard = 0;
        int gap_left = gap_len;
        cap_val = '0; cap_len = 0; stall_cnt = 0; end_off = -1;
        model_push(bits, n);
        while (i < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (i == abort_at) begin
                bus.in_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (i == gap_at && gap_left > 0) begin
                bus.in_valid = 1'b0;
                gap_left--;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_bit   = bits[i];
                bus.in_start = (i == 0);
                bus.in_end   = (i == n - 1);
                if (!bus.stall) i++;
            end
        end
        chk("drive_timeout", (guard < 200) ? 1 : 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_start = 1'b0; bus.in_end = 1'b0; bus.in_bit = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((exp_q.size() != 0 || end_due) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", (k < 100) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_pkt(input string name, input logic [31:0] v, input int len,
                             input int off, input int stalls, input int stuffs);
        chk({name, "_bits"},   int'(cap_val), int'(v));
        chk({name, "_len"},    cap_len,   len);
        chk({name, "_endoff"}, end_off,   off);
        chk({name, "_stalls"}, stall_cnt, stalls);
`ifdef BIT_STUFF_STATS_EN
        chk({name, "_stuff_cnt"}, bus.stuff_cnt, stuffs);
`else
        if (stuffs < 0) $display("negative stuff count requested");
`endif
        $display("packet %s: len=%0d bits=%h end_off=%0d stalls=%0d", name, cap_len, cap_val, end_off, stall_cnt);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_start = 1'b0; bus.in_end = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Stray bits without in_start while IDLE must be dropped.
        repeat (3) begin
            bus.in_valid = 1'b1; bus.in_bit = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.in_bit = 1'b0;
        repeat (2) @(negedge clk);

        send_packet(32'h55, 8, -1, 0, -1);          wait_done();
        check_pkt("alt55", 32'h55, 8, 8, 0, 0);
        send_packet(32'h7F, 7, -1, 0, -1);          wait_done();
        check_pkt("ones7", 32'hBF, 8, 8, 1, 1);
        send_packet(32'h3F, 6, -1, 0, -1);          wait_done();
        check_pkt("ones6", 32'h3F, 7, 7, 1, 1);
        send_packet(32'hFDF, 12, -1, 0, -1);        wait_done();
        check_pkt("run5_run6", 32'h0FDF, 13, 13, 1, 1);
        send_packet(32'hFFF, 12, -1, 0, -1);        wait_done();
        check_pkt("ones12", 32'h1FBF, 14, 14, 2, 2);
        send_packet(32'h7F, 7, 5, 3, -1);           wait_done();
        check_pkt("gap7", 32'hBF, 8, 11, 1, 1);
        send_packet(32'h1, 1, -1, 0, -1);           wait_done();
        check_pkt("single", 32'h1, 1, 1, 0, 0);

        send_packet(32'h3FF, 10, -1, 0, 4);         wait_done();
        chk("abort_len",    cap_len, 4);
        chk("abort_no_end", end_off, -1);
`ifdef BIT_STUFF_STATS_EN
        chk("abort_stuff_cnt", bus.stuff_cnt, 0);
`endif
        $display("packet abort: len=%0d end_off=%0d", cap_len, end_off);

        send_packet(32'h7F, 7, -1, 0, -1);          wait_done();
        check_pkt("after_abort", 32'hBF, 8, 8, 1, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/usb_bit_stuffer.md
Name: usb_bit_stuffer

Overview:
- Transmit-path stage directly upstream of the NRZI encoder.
- Takes the serialized packet bit stream (SYNC through CRC) from the packet serializer.
- After every RUN_LEN consecutive 1 bits, inserts a 0 bit and stalls the serializer for one cycle.
- Produces the bit stream plus start and end strobes in the form the NRZI encoder consumes: data_start with the first bit, data_end the cycle after the last bit.

Parameters:
RUN_LEN, 6, number of consecutive 1s after which a 0 is inserted (USB = 6); legal range 2..15.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  in_bit is presented this cycle.
in_bit  input  1  serialized data bit; held stable by upstream while stall=1.
in_start  input  1  pulse, qualified by in_valid, marks the first bit of a packet.
in_end  input  1  pulse, qualified by in_valid, marks the last bit of a packet; may coincide with in_start.
stall  output  1  upstream must not advance; bit on in_bit is not consumed this cycle.
out_valid  output  1  out_bit is valid.
out_bit  output  1  stuffed bit stream to the NRZI encoder inb.
out_start  output  1  pulse with the first out_bit of a packet (NRZI data_start).
out_end  output  1  pulse one cycle after the last out_bit, including a trailing stuffed bit (NRZI data_end).

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, ones counter=0, end_pend=0.
  - stall, out_valid, out_bit, out_start, out_end all 0.
  - Reset mid-packet aborts with no out_end.
- All outputs are registered except stall, which is decoded from the state register (no combinational input→output path).
- A bit is consumed on a posedge where in_valid=1 and stall=0. Latency is 1 cycle: out_bit appears the cycle after consumption.
- Ones counter, width $clog2(RUN_LEN+1):
  - A consumed 1 increments it.
  - A consumed 0 or an inserted 0 clears it.
  - in_start clears it before counting its own bit.
- State IDLE:
  - in_valid & in_start → consume; out_start=1; go SEND (or STUFF/FINISH per the rules below).
  - in_valid without in_start → bit dropped, stays IDLE, outputs idle.
- State SEND:
  - in_valid → consume; out_valid=1.
  - in_valid=0 → out_valid=0 and the counter is held (gap tolerated, no stuffing effect).
  - in_start seen in SEND is treated as an ordinary bit (no restart).
- Stuffing: when a consumed bit makes the counter reach RUN_LEN:
  - next state = STUFF; end_pend <= in_end.
  - In STUFF: stall=1; the next posedge emits out_bit=0 with out_valid=1 and clears the counter.
  - Then → FINISH if end_pend, else SEND.
- End:
  - A consumed bit with in_end and no stuff required → FINISH.
  - FINISH: out_valid=0, out_end=1 for exactly one cycle, then → IDLE. stall=0 in FINISH; any in_valid in FINISH is ignored.
- Sequence for a stuffed last bit: last 1 on out_bit, then stuffed 0, then the out_end cycle.
- The counter does not carry across packets.
- out_start and out_end are never both high in the same cycle.

Optional Feature:
- Macro BIT_STUFF_STATS_EN.
- When defined:
  - Extra output stuff_cnt[7:0] counts inserted 0s in the current packet, saturating at 255.
  - Cleared when in_start is consumed.
  - Holds its final value from the out_end cycle until the next in_start.
  - Reset value 0.
- When undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 → all outputs 0, stall=0.
- Packet 8'b0101_0101 (LSB first), start/end marked → out_start with bit 1, 8 out bits identical, out_end on cycle 9, stall never asserted.
- Packet of 7 ones → out = 1,1,1,1,1,1,0,1; stall high exactly 1 cycle after the 6th bit is emitted; out_end after 8 output bits; stuff_cnt=1 when BIT_STUFF_STATS_EN is defined.
- Packet of exactly 6 ones, in_end on the 6th → out = 111111 then 0, out_end in the cycle after the stuffed 0.
- Packet 111110 followed by 111111 → no stuff after the first five 1s (counter cleared by 0); one stuff after the final six.
- Reset mid-packet (rst at bit 4 of 10) → outputs go 0 the next cycle, no out_end; the next packet starts cleanly with counter 0.
